// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register file write-back arbiter: pipeline results vs queued long-latency results
// Optional feature macro: WB_STARVE_EN (forces a FIFO slot after STARVE_LIMIT waiting cycles)
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        pipeValid,
    input  logic [4:0]  pipeAddress,
    input  logic [31:0] pipeData,
    output logic        pipeStall,
    input  logic        longValid,
    input  logic [4:0]  longAddress,
    input  logic [31:0] longData,
    output logic        longReady,
    output logic        shouldWrite,
    output logic [4:0]  writeAddress,
    output logic [31:0] writeData,
    output logic [3:0]  pendingCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [3:0]       count;

    logic nonempty;
    logic accept;
    logic enqueue;
    logic enq_valid;
    logic pipe_req;
    logic pop_stall;
    logic sel_pipe;
    logic pop;

    assign pendingCount = count;
    assign nonempty     = (count != 4'd0);
    // Readiness depends on current occupancy only, so a full FIFO is not ready even on a pop cycle.
    assign longReady    = resetN && (count < 4'(DEPTH));
    assign accept       = longValid && longReady;
    assign enqueue      = accept && (longAddress != 5'd0);

`ifdef WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          stall_q;
    logic          starve_hit;

    assign starve_hit = nonempty && !pop && (starve_cnt == SW'(STARVE_LIMIT - 1));
    assign pipeStall  = stall_q;
    assign pop_stall  = stall_q && nonempty;
    assign pipe_req   = pipeValid && (pipeAddress != 5'd0) && !stall_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= starve_hit;
            if (!nonempty || pop || starve_hit)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    no_pipe_during_stall: assert property (@(posedge clock) disable iff (!resetN)
        !(pipeStall && pipeValid));
`else
    assign pipeStall = 1'b0;
    assign pop_stall = 1'b0;
    assign pipe_req  = pipeValid && (pipeAddress != 5'd0);
`endif

    assign sel_pipe  = !pop_stall && pipe_req;
    assign pop       = pop_stall || (!sel_pipe && nonempty);
    // An entry accepted on the same edge as a pipe write to its register is born dead.
    assign enq_valid = !(sel_pipe && (longAddress == pipeAddress));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shouldWrite  <= 1'b0;
            writeAddress <= 5'd0;
            writeData    <= 32'd0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= 4'd0;
            q_valid      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= 5'd0;
                q_data[i] <= 32'd0;
            end
        end else begin
            if (sel_pipe) begin
                shouldWrite  <= 1'b1;
                writeAddress <= pipeAddress;
                writeData    <= pipeData;
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_addr[i] == pipeAddress)
                        q_valid[i] <= 1'b0;
                end
            end else if (pop) begin
                shouldWrite  <= q_valid[rd_ptr];
                writeAddress <= q_addr[rd_ptr];
                writeData    <= q_data[rd_ptr];
                rd_ptr       <= rd_ptr + PW'(1);
            end else begin
                shouldWrite <= 1'b0;
            end

            if (enqueue) begin
                q_addr[wr_ptr]  <= longAddress;
                q_data[wr_ptr]  <= longData;
                q_valid[wr_ptr] <= enq_valid;
                wr_ptr          <= wr_ptr + PW'(1);
            end

            count <= count + {3'b000, enqueue} - {3'b000, pop};
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

    logic        clock;
    logic        resetN;
    logic        pipeValid;
    logic [4:0]  pipeAddress;
    logic [31:0] pipeData;
    logic        pipeStall;
    logic        longValid;
    logic [4:0]  longAddress;
    logic [31:0] longData;
    logic        longReady;
    logic        shouldWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [3:0]  pendingCount;

    int tests_run    = 0;
    int tests_failed = 0;

    writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .pipeValid    (pipeValid),
        .pipeAddress  (pipeAddress),
        .pipeData     (pipeData),
        .pipeStall    (pipeStall),
        .longValid    (longValid),
        .longAddress  (longAddress),
        .longData     (longData),
        .longReady    (longReady),
        .shouldWrite  (shouldWrite),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .pendingCount (pendingCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipeValid   = pv;
        pipeAddress = pa;
        pipeData    = pd;
        longValid   = lv;
        longAddress = la;
        longData    = ld;
    endtask

    task automatic check_out(input string tag, input logic sw, input logic [4:0] wa,
                             input logic [31:0] wd, input logic [3:0] cnt);
        check_val({tag, ".shouldWrite"}, {31'd0, shouldWrite}, {31'd0, sw});
        if (sw) begin
            check_val({tag, ".writeAddress"}, {27'd0, writeAddress}, {27'd0, wa});
            check_val({tag, ".writeData"}, writeData, wd);
        end
        check_val({tag, ".pendingCount"}, {28'd0, pendingCount}, {28'd0, cnt});
    endtask

    initial begin
        resetN = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check_val("rst.shouldWrite", {31'd0, shouldWrite}, 32'd0);
        check_val("rst.writeAddress", {27'd0, writeAddress}, 32'd0);
        check_val("rst.writeData", writeData, 32'd0);
        check_val("rst.pendingCount", {28'd0, pendingCount}, 32'd0);
        check_val("rst.longReady", {31'd0, longReady}, 32'd0);
        check_val("rst.pipeStall", {31'd0, pipeStall}, 32'd0);
        step();
        resetN = 1'b1;
        #1;
        check_val("rel.longReady", {31'd0, longReady}, 32'd1);

        // single pipeline write, then idle holds address/data
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        check_out("t1.pipe", 1, 5, 32'hDEADBEEF, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t1.idle", 0, 0, 0, 0);
        check_val("t1.hold_addr", {27'd0, writeAddress}, 32'd5);
        check_val("t1.hold_data", writeData, 32'hDEADBEEF);

        // zero-address requests are no-ops
        drive(1, 0, 32'h5555, 1, 0, 32'h6666);
        step();
        check_out("t1.zero", 0, 0, 0, 0);

        // two long results, pipe idle
        drive(0, 0, 0, 1, 3, 32'h33);
        check_val("t2.ready3", {31'd0, longReady}, 32'd1);
        step();
        check_out("t2.acc3", 0, 0, 0, 1);
        drive(0, 0, 0, 1, 4, 32'h44);
        check_val("t2.ready4", {31'd0, longReady}, 32'd1);
        step();
        check_out("t2.wr3", 1, 3, 32'h33, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t2.wr4", 1, 4, 32'h44, 0);
        step();
        check_out("t2.idle", 0, 0, 0, 0);

        // full FIFO with busy pipe
        drive(1, 20, 32'h2020, 1, 7, 32'h70);
        step();
        check_out("t3.p20", 1, 20, 32'h2020, 1);
        drive(1, 21, 32'h2121, 1, 8, 32'h80);
        check_val("t3.ready8", {31'd0, longReady}, 32'd1);
        step();
        check_out("t3.p21", 1, 21, 32'h2121, 2);
        check_val("t3.full_ready", {31'd0, longReady}, 32'd0);
        drive(1, 22, 32'h2222, 1, 9, 32'h90);
        step();
        check_out("t3.p22", 1, 22, 32'h2222, 2);
        check_val("t3.still_full", {31'd0, longReady}, 32'd0);
        drive(0, 0, 0, 1, 9, 32'h90);
        step();
        check_out("t3.wr7", 1, 7, 32'h70, 1);
        check_val("t3.ready9", {31'd0, longReady}, 32'd1);
        step();
        check_out("t3.wr8", 1, 8, 32'h80, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t3.wr9", 1, 9, 32'h90, 0);

        // WAW kill of an older queued entry
        drive(0, 0, 0, 1, 6, 32'h66);
        step();
        check_out("t4.acc6", 0, 0, 0, 1);
        drive(1, 6, 32'h11, 0, 0, 0);
        step();
        check_out("t4.pipe6", 1, 6, 32'h11, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t4.killed", 0, 0, 0, 0);

        // same-edge kill of an entry being accepted
        drive(1, 12, 32'h12, 1, 12, 32'hCC);
        step();
        check_out("t4.same", 1, 12, 32'h12, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t4.same_killed", 0, 0, 0, 0);

        // async reset mid-operation
        drive(1, 25, 32'h2525, 1, 13, 32'hD0);
        step();
        drive(1, 26, 32'h2626, 1, 14, 32'hE0);
        step();
        check_out("t5.pre", 1, 26, 32'h2626, 2);
        resetN = 1'b0;
        #1;
        check_val("t5.sw", {31'd0, shouldWrite}, 32'd0);
        check_val("t5.cnt", {28'd0, pendingCount}, 32'd0);
        check_val("t5.ready", {31'd0, longReady}, 32'd0);
        check_val("t5.addr", {27'd0, writeAddress}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        resetN = 1'b1;
        step();
        check_out("t5.post1", 0, 0, 0, 0);
        step();
        check_out("t5.post2", 0, 0, 0, 0);

`ifdef WB_STARVE_EN
        // starvation: head forced out after waiting with a busy pipe
        drive(1, 27, 32'h27, 1, 15, 32'hF5);
        step();
        check_out("t6.acc", 1, 27, 32'h27, 1);
        check_val("t6.stall0", {31'd0, pipeStall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(28 + i), 32'(i), 0, 0, 0);
            step();
            check_val("t6.nostall", {31'd0, pipeStall}, 32'd0);
        end
        drive(1, 31, 32'h31, 0, 0, 0);
        step();
        check_val("t6.stall", {31'd0, pipeStall}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_out("t6.forced", 1, 15, 32'hF5, 0);
        check_val("t6.stall_low", {31'd0, pipeStall}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
